m_btb_predictor: RTL and testbench
==================================

# m_btb_predictor

Parametrised branch target buffer with saturating-counter direction prediction. It replaces the fixed single-target, bne-only destination memory in the fetch stage. The fetch stage looks up the current PC every cycle and gets a hit, taken and target answer aligned with the instruction-memory output one cycle later. The execute/memory stage writes back resolved branch outcomes. Tagged entries, valid bits, flush and performance counters are new relative to the previous generation.

## Interface
- ENTRIES, 64: number of direct-mapped entries; power of two, 4..4096.
- TAG_W, 8: tag bits stored per entry, taken from pc above the index field.
- CNT_W, 2: direction counter width, 1..4.
- PERF_W, 32: width of the performance counters.
- w_clk  in  1  clock; all state changes on posedge.
- w_rst_n  in  1  reset; asynchronous, active-low.
- w_ce  in  1  clock enable; when low, no state or output changes.
- w_flush  in  1  synchronous invalidate of all entries.
- w_lk_pc  in  32  fetch PC to predict.
- r_lk_hit  out  1  registered: entry valid and tag matched.
- r_lk_taken  out  1  registered: r_lk_hit and counter MSB set.
- r_lk_target  out  32  registered predicted target; 0 when r_lk_hit is 0.
- w_up_valid  in  1  resolved-branch update strobe.
- w_up_pc  in  32  PC of the resolved branch.
- w_up_taken  in  1  actual direction.
- w_up_target  in  32  actual taken target.
- r_n_lookup  out  PERF_W  number of enabled lookup cycles.
- r_n_hit  out  PERF_W  number of lookups that hit.
- r_n_update  out  PERF_W  number of accepted updates.

## Operation
- Field mapping: IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Per-entry state: valid (flop, async-cleared), tag, target, and a CNT_W-bit counter.
- Lookup runs every w_ce cycle:
  - hit = valid[idx] && tag match.
  - The result is registered.
  - On a miss, r_lk_taken = 0 and r_lk_target = 0.
- Update on a hit (same index and tag):
  - Counter increments if taken, decrements if not taken.
  - Counter saturates at 2^CNT_W-1 and at 0.
  - Target is overwritten only when the branch was taken.
- Update on a miss:
  - If taken: allocate the entry. Set valid=1, write tag and target, and set counter = WEAK_T = 2^(CNT_W-1). Any previous occupant is evicted.
  - If not taken: no change.
- w_flush clears every valid bit. It has priority over a same-cycle update, which is dropped. The lookup in that same cycle still uses the pre-flush state.
- Simultaneous lookup and update to the same index: read-first. The lookup sees the contents from before the update. The write takes effect for lookups in the next cycle.
- Performance counters:
  - r_n_lookup increments on every w_ce cycle.
  - r_n_hit increments when a hit is registered.
  - r_n_update increments on every w_up_valid cycle while w_ce is high and w_flush is low, whether or not anything is allocated.
  - All three saturate at all-ones and do not wrap.
  - The counters are not cleared by w_flush.
- Reset asserted: all outputs 0, all valid bits 0, performance counters 0. Counter, tag and target contents are don't-care because valid gates them. Reset asserted mid-update discards that update.

## Timing
- Lookup latency: 1 cycle. A PC presented at edge N produces a result visible after edge N+1. This matches the synchronous instruction memory, so the prediction and the instruction arrive together.
- Update latency: the write commits at the edge where w_up_valid is sampled. It is visible to a lookup sampled at the next edge.
- w_ce low holds all registers, including the outputs and performance counters.
- Reset deassertion is synchronised externally. The first lookup edge after deassertion returns a miss.

## Structure
- Shared package btb_pkg holds:
  - the CNT_W-generic saturating inc/dec function;
  - the WEAK_T constant;
  - the index and tag extract functions.
- One sub-module, m_btb_ram:
  - ENTRIES x (TAG_W+32+CNT_W) storage;
  - one asynchronous read port for the update read-modify-write;
  - one read port registered into the lookup result;
  - one write port.
- The valid bits and performance counters live in the top module, because only they need asynchronous reset.

## Test plan
- Reset, then lookup 0x100 -> hit=0, taken=0, target=0; r_n_lookup=1, r_n_hit=0.
- Update pc=0x100 taken target=0x80, then lookup 0x100 -> hit=1, taken=1 (counter 2), target=0x80.
- Continuing from the previous scenario, three not-taken updates to 0x100 -> the counter goes 1, then 0, then stays 0. Lookup -> hit=1, taken=0, target still 0x80.
- ENTRIES=64, TAG_W=8. Allocate 0x100, then allocate 0x200 (same index, different tag) -> 0x200 evicts 0x100. A lookup of 0x100 now misses.
- Same-cycle update (allocate 0x40 -> 0x400) and lookup of 0x40 -> that lookup misses. The next lookup of 0x40 hits with target 0x400.
- Populate 4 entries, assert w_flush together with an update -> all lookups miss afterwards, the update is dropped, and r_n_update is not incremented. Separately, assert w_rst_n low mid-run -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared helpers for the branch target buffer: PC field extraction,
// the width-generic saturating direction counter and its weak-taken seed.
`timescale 1ns/1ps
package btb_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned CNT_MAX_W = 4;

  typedef logic [CNT_MAX_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    UP_NONE  = 2'd0,
    UP_TRAIN = 2'd1,
    UP_ALLOC = 2'd2
  } up_act_e;

  // WEAK_T = 2^(cnt_w-1): lowest counter value whose MSB reads as taken.
  function automatic cnt_t f_weak_t(input int unsigned cnt_w);
    return cnt_t'(32'd1 << (cnt_w - 1));
  endfunction

  function automatic cnt_t f_sat_step(input cnt_t cnt, input logic up,
                                      input int unsigned cnt_w);
    cnt_t max_v;
    max_v = cnt_t'((32'd1 << cnt_w) - 32'd1);
    if (up) begin
      return (cnt >= max_v) ? max_v : cnt + cnt_t'(1);
    end
    return (cnt == '0) ? '0 : cnt - cnt_t'(1);
  endfunction

  function automatic logic [PC_W-1:0] f_idx(input logic [PC_W-1:0] pc,
                                            input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [PC_W-1:0] f_tag(input logic [PC_W-1:0] pc,
                                            input int unsigned idx_w,
                                            input int unsigned tag_w);
    logic [PC_W-1:0] mask;
    mask = (tag_w >= PC_W) ? '1 : ((32'd1 << tag_w) - 32'd1);
    return (pc >> (idx_w + 2)) & mask;
  endfunction

endpackage

// File: rtl/m_btb_ram.sv
// Entry storage for the BTB: one write port and two asynchronous read
// ports (fetch lookup and update read-modify-write).
`timescale 1ns/1ps
module m_btb_ram #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned DATA_W  = 42
) (
  input  logic              w_clk,
  input  logic              w_we,
  input  logic [IDX_W-1:0]  w_wr_idx,
  input  logic [DATA_W-1:0] w_wr_data,
  input  logic [IDX_W-1:0]  w_rd_a_idx,
  output logic [DATA_W-1:0] w_rd_a_data,
  input  logic [IDX_W-1:0]  w_rd_b_idx,
  output logic [DATA_W-1:0] w_rd_b_data
);

  // No reset: contents are meaningless until the matching valid bit is set.
  logic [DATA_W-1:0] r_mem [ENTRIES];

  always_ff @(posedge w_clk) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  assign w_rd_a_data = r_mem[w_rd_a_idx];
  assign w_rd_b_data = r_mem[w_rd_b_idx];

endmodule

// File: rtl/m_btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, registered one-cycle lookup, resolved-branch update and perf counters.
`timescale 1ns/1ps
module m_btb_predictor
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_ce,
  input  logic              w_flush,
  input  logic [31:0]       w_lk_pc,
  output logic              r_lk_hit,
  output logic              r_lk_taken,
  output logic [31:0]       r_lk_target,
  input  logic              w_up_valid,
  input  logic [31:0]       w_up_pc,
  input  logic              w_up_taken,
  input  logic [31:0]       w_up_target,
  output logic [PERF_W-1:0] r_n_lookup,
  output logic [PERF_W-1:0] r_n_hit,
  output logic [PERF_W-1:0] r_n_update
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned DATA_W = TAG_W + 32 + CNT_W;
  localparam logic [CNT_W-1:0] WEAK_T = CNT_W'(f_weak_t(CNT_W));

  logic [ENTRIES-1:0] r_valid;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;

  logic [DATA_W-1:0] w_lk_data;
  logic [DATA_W-1:0] w_up_data;
  logic [TAG_W-1:0]  w_lk_ent_tag;
  logic [31:0]       w_lk_ent_target;
  logic [CNT_W-1:0]  w_lk_ent_cnt;
  logic [TAG_W-1:0]  w_up_ent_tag;
  logic [31:0]       w_up_ent_target;
  logic [CNT_W-1:0]  w_up_ent_cnt;

  logic              w_lk_hit;
  logic              w_up_hit;
  up_act_e           w_up_act;
  logic [CNT_W-1:0]  w_wr_cnt;
  logic [31:0]       w_wr_target;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_accept_up;
  logic              w_we;

  assign w_lk_idx = IDX_W'(f_idx(w_lk_pc, IDX_W));
  assign w_lk_tag = TAG_W'(f_tag(w_lk_pc, IDX_W, TAG_W));
  assign w_up_idx = IDX_W'(f_idx(w_up_pc, IDX_W));
  assign w_up_tag = TAG_W'(f_tag(w_up_pc, IDX_W, TAG_W));

  m_btb_ram #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) u_ram (
    .w_clk       (w_clk),
    .w_we        (w_we),
    .w_wr_idx    (w_up_idx),
    .w_wr_data   (w_wr_data),
    .w_rd_a_idx  (w_lk_idx),
    .w_rd_a_data (w_lk_data),
    .w_rd_b_idx  (w_up_idx),
    .w_rd_b_data (w_up_data)
  );

  assign {w_lk_ent_tag, w_lk_ent_target, w_lk_ent_cnt} = w_lk_data;
  assign {w_up_ent_tag, w_up_ent_target, w_up_ent_cnt} = w_up_data;

  // Both reads are combinational from pre-edge state, so a same-index
  // lookup and update are naturally read-first.
  assign w_lk_hit = r_valid[w_lk_idx] && (w_lk_ent_tag == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (w_up_ent_tag == w_up_tag);

  always_comb begin
    w_up_act = UP_NONE;
    if (w_up_valid) begin
      if (w_up_hit) begin
        w_up_act = UP_TRAIN;
      end else if (w_up_taken) begin
        w_up_act = UP_ALLOC;
      end
    end
  end

  always_comb begin
    w_wr_cnt    = WEAK_T;
    w_wr_target = w_up_target;
    if (w_up_act == UP_TRAIN) begin
      w_wr_cnt    = CNT_W'(f_sat_step(cnt_t'(w_up_ent_cnt), w_up_taken, CNT_W));
      w_wr_target = w_up_taken ? w_up_target : w_up_ent_target;
    end
    w_wr_data = {w_up_tag, w_wr_target, w_wr_cnt};
  end

  assign w_accept_up = w_ce && !w_flush && w_up_valid;
  // Reset gates the write so an update caught by reset leaves no trace.
  assign w_we = w_rst_n && w_ce && !w_flush && (w_up_act != UP_NONE);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_valid     <= '0;
      r_lk_hit    <= 1'b0;
      r_lk_taken  <= 1'b0;
      r_lk_target <= '0;
    end else if (w_ce) begin
      r_lk_hit    <= w_lk_hit;
      r_lk_taken  <= w_lk_hit && w_lk_ent_cnt[CNT_W-1];
      r_lk_target <= w_lk_hit ? w_lk_ent_target : '0;
      if (w_flush) begin
        r_valid <= '0;
      end else if (w_up_act == UP_ALLOC) begin
        r_valid[w_up_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_n_lookup <= '0;
      r_n_hit    <= '0;
      r_n_update <= '0;
    end else if (w_ce) begin
      if (r_n_lookup != '1) begin
        r_n_lookup <= r_n_lookup + PERF_W'(1);
      end
      if (w_lk_hit && (r_n_hit != '1)) begin
        r_n_hit <= r_n_hit + PERF_W'(1);
      end
      if (w_accept_up && (r_n_update != '1)) begin
        r_n_update <= r_n_update + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_m_btb_predictor.sv
// Self-checking bench for m_btb_predictor: an entry-level behavioural model
// checked every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_m_btb_predictor;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned PERF_W  = 32;

  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam int          CNT_HALF = 1 << (CNT_W - 1);
  localparam longint      PERF_MAX = (64'd1 << PERF_W) - 1;

  logic              w_clk = 1'b0;
  logic              w_rst_n;
  logic              w_ce;
  logic              w_flush;
  logic [31:0]       w_lk_pc;
  logic              r_lk_hit;
  logic              r_lk_taken;
  logic [31:0]       r_lk_target;
  logic              w_up_valid;
  logic [31:0]       w_up_pc;
  logic              w_up_taken;
  logic [31:0]       w_up_target;
  logic [PERF_W-1:0] r_n_lookup;
  logic [PERF_W-1:0] r_n_hit;
  logic [PERF_W-1:0] r_n_update;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 w_clk = ~w_clk;

  m_btb_predictor #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W),
    .PERF_W  (PERF_W)
  ) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_ce        (w_ce),
    .w_flush     (w_flush),
    .w_lk_pc     (w_lk_pc),
    .r_lk_hit    (r_lk_hit),
    .r_lk_taken  (r_lk_taken),
    .r_lk_target (r_lk_target),
    .w_up_valid  (w_up_valid),
    .w_up_pc     (w_up_pc),
    .w_up_taken  (w_up_taken),
    .w_up_target (w_up_target),
    .r_n_lookup  (r_n_lookup),
    .r_n_hit     (r_n_hit),
    .r_n_update  (r_n_update)
  );

  // ---------------- behavioural model ----------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  logic        e_hit      = 1'b0;
  logic        e_taken    = 1'b0;
  logic [31:0] e_target   = '0;
  longint      e_n_lookup = 0;
  longint      e_n_hit    = 0;
  longint      e_n_update = 0;

  always @(posedge w_clk or negedge w_rst_n) begin : model
    int          li;
    int          ui;
    int unsigned lt;
    int unsigned ut;
    bit          lh;
    bit          uh;
    if (!w_rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
      e_hit = 1'b0; e_taken = 1'b0; e_target = '0;
      e_n_lookup = 0; e_n_hit = 0; e_n_update = 0;
    end else if (w_ce) begin
      li = int'((w_lk_pc / 4) % ENTRIES);
      lt = (w_lk_pc / (4 * ENTRIES)) % (1 << TAG_W);
      ui = int'((w_up_pc / 4) % ENTRIES);
      ut = (w_up_pc / (4 * ENTRIES)) % (1 << TAG_W);
      lh = m_valid[li] && (m_tag[li] == lt);
      uh = m_valid[ui] && (m_tag[ui] == ut);
      e_hit    = lh;
      e_taken  = lh && (m_cnt[li] >= CNT_HALF);
      e_target = lh ? m_target[li] : 32'd0;
      if (e_n_lookup < PERF_MAX) e_n_lookup++;
      if (lh && e_n_hit < PERF_MAX) e_n_hit++;
      if (w_flush) begin
        for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
      end else if (w_up_valid) begin
        if (e_n_update < PERF_MAX) e_n_update++;
        if (uh) begin
          if (w_up_taken) begin
            if (m_cnt[ui] < CNT_MAX) m_cnt[ui]++;
            m_target[ui] = w_up_target;
          end else if (m_cnt[ui] > 0) begin
            m_cnt[ui]--;
          end
        end else if (w_up_taken) begin
          m_valid[ui]  = 1'b1;
          m_tag[ui]    = ut;
          m_target[ui] = w_up_target;
          m_cnt[ui]    = CNT_HALF;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge w_clk) begin
    if (cmp_en) begin
      check("model_hit",      64'(r_lk_hit),    64'(e_hit));
      check("model_taken",    64'(r_lk_taken),  64'(e_taken));
      check("model_target",   64'(r_lk_target), 64'(e_target));
      check("model_n_lookup", 64'(r_n_lookup),  64'(e_n_lookup));
      check("model_n_hit",    64'(r_n_hit),     64'(e_n_hit));
      check("model_n_update", 64'(r_n_update),  64'(e_n_update));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic up(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    w_up_valid  = v;
    w_up_pc     = pc;
    w_up_taken  = tk;
    w_up_target = tg;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_rst_n = 1'b0; w_ce = 1'b1; w_flush = 1'b0; w_lk_pc = '0;
    up(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
    cmp_en = 1'b1;
    check("rst_hit",      64'(r_lk_hit),    64'd0);
    check("rst_target",   64'(r_lk_target), 64'd0);
    check("rst_n_lookup", 64'(r_n_lookup),  64'd0);

    w_lk_pc = 32'h100; w_rst_n = 1'b1;
    tick();
    check("first_hit",      64'(r_lk_hit),    64'd0);
    check("first_taken",    64'(r_lk_taken),  64'd0);
    check("first_target",   64'(r_lk_target), 64'd0);
    check("first_n_lookup", 64'(r_n_lookup),  64'd1);
    check("first_n_hit",    64'(r_n_hit),     64'd0);

    up(1'b1, 32'h100, 1'b1, 32'h80);
    tick();
    check("alloc_readfirst_hit", 64'(r_lk_hit), 64'd0);
    up(1'b0, '0, 1'b0, '0);
    tick();
    check("alloc_hit",      64'(r_lk_hit),    64'd1);
    check("alloc_taken",    64'(r_lk_taken),  64'd1);
    check("alloc_target",   64'(r_lk_target), 64'h80);
    check("alloc_n_update", 64'(r_n_update),  64'd1);

    up(1'b1, 32'h100, 1'b0, 32'h999);
    repeat (3) tick();
    up(1'b0, '0, 1'b0, '0);
    tick();
    check("nt_hit",    64'(r_lk_hit),    64'd1);
    check("nt_taken",  64'(r_lk_taken),  64'd0);
    check("nt_target", 64'(r_lk_target), 64'h80);

    up(1'b1, 32'h100, 1'b1, 32'h80);  tick();
    up(1'b1, 32'h200, 1'b1, 32'h300); tick();
    up(1'b0, '0, 1'b0, '0);           tick();
    check("evict_old_hit", 64'(r_lk_hit), 64'd0);
    w_lk_pc = 32'h200; tick();
    check("evict_new_hit",    64'(r_lk_hit),    64'd1);
    check("evict_new_target", 64'(r_lk_target), 64'h300);

    up(1'b1, 32'h40, 1'b1, 32'h400); w_lk_pc = 32'h40;
    tick();
    check("same_cycle_hit", 64'(r_lk_hit), 64'd0);
    up(1'b0, '0, 1'b0, '0);
    tick();
    check("next_cycle_hit",    64'(r_lk_hit),    64'd1);
    check("next_cycle_target", 64'(r_lk_target), 64'h400);

    up(1'b1, 32'h40, 1'b1, 32'h400); repeat (3) tick();
    up(1'b1, 32'h40, 1'b0, 32'h0);   tick();
    up(1'b0, '0, 1'b0, '0);          tick();
    check("sat_hi_taken", 64'(r_lk_taken), 64'd1);
    up(1'b1, 32'h40, 1'b0, 32'h0);   tick();
    up(1'b0, '0, 1'b0, '0);          tick();
    check("sat_hi_dec_taken", 64'(r_lk_taken), 64'd0);

    w_ce = 1'b0; up(1'b1, 32'h500, 1'b1, 32'h55); w_lk_pc = 32'h500;
    repeat (2) tick();
    check("ce_hold_hit",    64'(r_lk_hit),    64'd1);
    check("ce_hold_target", 64'(r_lk_target), 64'h400);
    w_ce = 1'b1; up(1'b0, '0, 1'b0, '0);
    tick();
    check("ce_no_alloc_hit", 64'(r_lk_hit), 64'd0);

    up(1'b1, 32'h600, 1'b0, 32'h66); w_lk_pc = 32'h600; tick();
    up(1'b0, '0, 1'b0, '0);          tick();
    check("nt_miss_no_alloc", 64'(r_lk_hit), 64'd0);

    for (int i = 0; i < 4; i++) begin
      up(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(i));
      tick();
    end
    up(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      w_lk_pc = 32'h1000 + 32'(4 * i);
      tick();
      check("populated_hit", 64'(r_lk_hit), 64'd1);
    end
    w_flush = 1'b1; up(1'b1, 32'h3000, 1'b1, 32'h77); w_lk_pc = 32'h1004;
    tick();
    check("flush_preflush_hit",    64'(r_lk_hit),    64'd1);
    check("flush_preflush_target", 64'(r_lk_target), 64'h2001);
    w_flush = 1'b0; up(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      w_lk_pc = 32'h1000 + 32'(4 * i);
      tick();
      check("flushed_hit", 64'(r_lk_hit), 64'd0);
    end
    w_lk_pc = 32'h3000; tick();
    check("flush_drop_update_hit", 64'(r_lk_hit), 64'd0);

    up(1'b1, 32'h700, 1'b1, 32'h70); tick();
    up(1'b0, '0, 1'b0, '0); w_lk_pc = 32'h700; tick();
    check("pre_reset_hit", 64'(r_lk_hit), 64'd1);
    #3 w_rst_n = 1'b0;
    #1;
    check("async_rst_hit",      64'(r_lk_hit),    64'd0);
    check("async_rst_target",   64'(r_lk_target), 64'd0);
    check("async_rst_n_lookup", 64'(r_n_lookup),  64'd0);
    check("async_rst_n_update", 64'(r_n_update),  64'd0);
    repeat (2) tick();
    w_rst_n = 1'b1;
    tick();
    check("post_reset_hit", 64'(r_lk_hit), 64'd0);

    cmp_en = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
